// File: rtl/sm83_pkg.sv
// Shared SM83 types: decoded control ops, r8 register selects, decoder FSM states.
// Also holds the CB prefix opcode constant and the illegal-opcode predicate.
package sm83_pkg;

  typedef enum logic [3:0] {
    CTL_NOP,
    CTL_LD_R8_D8,
    CTL_LD_HL_D8,
    CTL_LD_R8_R8,
    CTL_HALT,
    CTL_CB_PREFIX,
    CTL_CB_OP,
    CTL_LOCK,
    CTL_UNIMPL
  } ctl_op_t;

  typedef enum logic [2:0] {
    R8_B      = 3'd0,
    R8_C      = 3'd1,
    R8_D      = 3'd2,
    R8_E      = 3'd3,
    R8_H      = 3'd4,
    R8_L      = 3'd5,
    R8_HL_IND = 3'd6,
    R8_A      = 3'd7
  } r8_sel_t;

  typedef enum logic [1:0] {
    MAIN,
    CB_PENDING,
    CB_EXEC,
    LOCKED
  } sm83_dec_state_t;

  localparam logic [7:0] OPC_CB_PREFIX = 8'hCB;

  // Holes in the SM83 opcode map; real silicon hangs on any of these.
  function automatic logic is_illegal_opcode(input logic [7:0] op);
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sm83_decode_if.sv
// Decoder <-> control sequencer bundle: fetch strobe and read data in, decoded op out.
// The decoder uses the slave modport; the sequencer (or a bench) uses master.
interface sm83_decode_if #(
  parameter int unsigned CNT_W = 32
);
  import sm83_pkg::*;

  logic             fetch_cycle;
  logic [7:0]       mem_rdata;
  ctl_op_t          ctl_op;
  r8_sel_t          dst_r8;
  r8_sel_t          src_r8;
  logic             cb_mode;
  logic             locked;
  logic [7:0]       opcode;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output fetch_cycle, mem_rdata,
    input  ctl_op, dst_r8, src_r8, cb_mode, locked, opcode, instr_count
  );

  modport slave (
    input  fetch_cycle, mem_rdata,
    output ctl_op, dst_r8, src_r8, cb_mode, locked, opcode, instr_count
  );

endinterface

// File: rtl/sm83_opcode_rom.sv
// Combinational map of {IR, cb page} to {ctl_op, dst_r8, src_r8}; zero latency.
module sm83_opcode_rom
  import sm83_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       cb,
  output ctl_op_t    ctl_op,
  output r8_sel_t    dst_r8,
  output r8_sel_t    src_r8
);

  always_comb begin
    ctl_op = CTL_NOP;
    dst_r8 = R8_B;
    src_r8 = R8_B;
    if (cb) begin
      // Every CB-page op works on the register in the low three bits.
      ctl_op = CTL_CB_OP;
      dst_r8 = r8_sel_t'(ir[2:0]);
      src_r8 = r8_sel_t'(ir[2:0]);
    end else if (is_illegal_opcode(ir)) begin
      // Only reachable when illegal opcodes are configured not to lock.
      ctl_op = CTL_NOP;
    end else begin
      casez (ir)
        8'h00:       ctl_op = CTL_NOP;
        8'h36:       ctl_op = CTL_LD_HL_D8;
        8'b00???110: begin
          ctl_op = CTL_LD_R8_D8;
          dst_r8 = r8_sel_t'(ir[5:3]);
        end
        8'h76:       ctl_op = CTL_HALT;
        8'b01??????: begin
          ctl_op = CTL_LD_R8_R8;
          dst_r8 = r8_sel_t'(ir[5:3]);
          src_r8 = r8_sel_t'(ir[2:0]);
        end
        OPC_CB_PREFIX: ctl_op = CTL_CB_PREFIX;
        default:       ctl_op = CTL_UNIMPL;
      endcase
    end
  end

endmodule

// File: rtl/sm83_decode.sv
// Instruction register + CB-prefix/lock FSM feeding the control sequencer; decode visible the cycle after capture.
// No backpressure: a byte is taken on every fetch_cycle posedge. Optional retire counter under SM83_INSTR_COUNT_EN.
module sm83_decode
  import sm83_pkg::*;
#(
  parameter int unsigned CNT_W           = 32,
  parameter bit          LOCK_ON_ILLEGAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  sm83_decode_if.slave bus
);

  sm83_dec_state_t state_q, state_d;
  logic [7:0]      ir_q, ir_d;

  ctl_op_t rom_op;
  r8_sel_t rom_dst;
  r8_sel_t rom_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MAIN;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      MAIN, CB_EXEC: begin
        if (bus.fetch_cycle) begin
          ir_d = bus.mem_rdata;
          if (bus.mem_rdata == OPC_CB_PREFIX)
            state_d = CB_PENDING;
          else if (LOCK_ON_ILLEGAL && is_illegal_opcode(bus.mem_rdata))
            state_d = LOCKED;
          else
            state_d = MAIN;
        end
      end
      CB_PENDING: begin
        // Second byte of a CB pair is always legal, even another CB.
        if (bus.fetch_cycle) begin
          ir_d    = bus.mem_rdata;
          state_d = CB_EXEC;
        end
      end
      default: begin
        state_d = LOCKED;
      end
    endcase
  end

  sm83_opcode_rom u_rom (
    .ir     (ir_q),
    .cb     (state_q == CB_EXEC),
    .ctl_op (rom_op),
    .dst_r8 (rom_dst),
    .src_r8 (rom_src)
  );

  always_comb begin
    bus.ctl_op  = rom_op;
    bus.dst_r8  = rom_dst;
    bus.src_r8  = rom_src;
    bus.cb_mode = (state_q == CB_EXEC);
    bus.locked  = (state_q == LOCKED);
    bus.opcode  = ir_q;
    if (state_q == LOCKED) begin
      bus.ctl_op = CTL_LOCK;
      bus.dst_r8 = R8_B;
      bus.src_r8 = R8_B;
    end
  end

`ifdef SM83_INSTR_COUNT_EN
  // A fetch outside CB_PENDING/LOCKED marks the retirement of the previous instruction.
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  assign retire = bus.fetch_cycle && (state_q == MAIN || state_q == CB_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (retire)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.instr_count = cnt_q;
`else
  assign bus.instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sm83_decode.sv
// Self-checking bench for sm83_decode: directed literal checks plus random fetch/reset traffic
// compared every cycle against a spec-level model, on a locking and a non-locking instance.
module tb_sm83_decode;
  import sm83_pkg::*;

  localparam int unsigned CW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch;
  logic [7:0] rdata;
  bit         run_cmp = 1'b0;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  sm83_decode_if #(.CNT_W(CW)) bus0 ();
  sm83_decode_if #(.CNT_W(CW)) bus1 ();

  assign bus0.fetch_cycle = fetch;
  assign bus0.mem_rdata   = rdata;
  assign bus1.fetch_cycle = fetch;
  assign bus1.mem_rdata   = rdata;

  sm83_decode #(.CNT_W(CW), .LOCK_ON_ILLEGAL(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sm83_decode #(.CNT_W(CW), .LOCK_ON_ILLEGAL(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned illegal_list[11] = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                                     8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};

  function automatic bit in_illegal(input logic [7:0] b);
    foreach (illegal_list[k]) if (illegal_list[k] == b) return 1'b1;
    return 1'b0;
  endfunction

  logic [7:0]    m_ir   [2];
  bit            m_pend [2];
  bit            m_cb   [2];
  bit            m_lock [2];
  logic [CW-1:0] m_cnt  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ir[i] <= 8'h00; m_pend[i] <= 1'b0; m_cb[i] <= 1'b0;
        m_lock[i] <= 1'b0; m_cnt[i] <= '0;
      end
    end else if (fetch) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_lock[i]) begin
          m_ir[i] <= rdata;
          if (m_pend[i]) begin
            m_pend[i] <= 1'b0;
            m_cb[i]   <= 1'b1;
          end else begin
            m_cnt[i]  <= m_cnt[i] + 1'b1;
            m_cb[i]   <= 1'b0;
            m_pend[i] <= (rdata == 8'hCB);
            m_lock[i] <= (i == 0) && in_illegal(rdata);
          end
        end
      end
    end
  end

  task automatic expect_decode(input logic [7:0] ir, input bit cb, input bit lk,
                               output int op, output int dst, output int src);
    op = int'(CTL_UNIMPL); dst = 0; src = 0;
    if (lk)                         op = int'(CTL_LOCK);
    else if (cb) begin              op = int'(CTL_CB_OP); dst = ir % 8; src = ir % 8; end
    else if (ir == 8'hCB)           op = int'(CTL_CB_PREFIX);
    else if (in_illegal(ir))        op = int'(CTL_NOP);
    else if (ir == 8'h00)           op = int'(CTL_NOP);
    else if (ir == 8'h76)           op = int'(CTL_HALT);
    else if (ir == 8'h36)           op = int'(CTL_LD_HL_D8);
    else if ((ir & 8'hC7) == 8'h06) begin op = int'(CTL_LD_R8_D8); dst = (ir / 8) % 8; end
    else if (ir >= 8'h40 && ir <= 8'h7F) begin
      op = int'(CTL_LD_R8_R8); dst = (ir / 8) % 8; src = ir % 8;
    end
  endtask

  task automatic cmp_one(input int i, input ctl_op_t op, input r8_sel_t dst, input r8_sel_t src,
                         input logic cbm, input logic lk, input logic [7:0] opc,
                         input logic [CW-1:0] cnt);
    int eop, edst, esrc, ecnt;
    expect_decode(m_ir[i], m_cb[i], m_lock[i], eop, edst, esrc);
`ifdef SM83_INSTR_COUNT_EN
    ecnt = int'(m_cnt[i]);
`else
    ecnt = 0;
`endif
    chk($sformatf("m%0d_ctl_op", i), int'(op), eop);
    chk($sformatf("m%0d_dst", i), int'(dst), edst);
    chk($sformatf("m%0d_src", i), int'(src), esrc);
    chk($sformatf("m%0d_cb_mode", i), int'(cbm), int'(m_cb[i]));
    chk($sformatf("m%0d_locked", i), int'(lk), int'(m_lock[i]));
    chk($sformatf("m%0d_opcode", i), int'(opc), int'(m_ir[i]));
    chk($sformatf("m%0d_count", i), int'(cnt), ecnt);
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      cmp_one(0, bus0.ctl_op, bus0.dst_r8, bus0.src_r8, bus0.cb_mode, bus0.locked, bus0.opcode, bus0.instr_count);
      cmp_one(1, bus1.ctl_op, bus1.dst_r8, bus1.src_r8, bus1.cb_mode, bus1.locked, bus1.opcode, bus1.instr_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_fetch(input logic [7:0] d);
    fetch = 1'b1;
    rdata = d;
    @(posedge clk);
    #1;
    fetch = 1'b0;
    rdata = 8'($urandom);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int cnt_exp(input int n);
`ifdef SM83_INSTR_COUNT_EN
    return n % (1 << CW);
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    rst_n = 1'b0;
    fetch = 1'b0;
    rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    run_cmp = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("idle_ctl_op", int'(bus0.ctl_op), int'(CTL_NOP));
      chk("idle_opcode", int'(bus0.opcode), 8'h00);
      chk("idle_locked", int'(bus0.locked), 0);
      chk("idle_count",  int'(bus0.instr_count), 0);
    end

    do_fetch(8'h3E);
    chk("3E_ctl_op", int'(bus0.ctl_op), int'(CTL_LD_R8_D8));
    chk("3E_dst",    int'(bus0.dst_r8), 7);
    do_fetch(8'h78);
    chk("78_ctl_op", int'(bus0.ctl_op), int'(CTL_LD_R8_R8));
    chk("78_dst",    int'(bus0.dst_r8), 7);
    chk("78_src",    int'(bus0.src_r8), 0);
    chk("78_count",  int'(bus0.instr_count), cnt_exp(2));

    do_fetch(8'hCB);
    chk("CB_ctl_op",  int'(bus0.ctl_op), int'(CTL_CB_PREFIX));
    chk("CB_cb_mode", int'(bus0.cb_mode), 0);
    chk("CB_count",   int'(bus0.instr_count), cnt_exp(3));
    do_fetch(8'h11);
    chk("CB11_ctl_op",  int'(bus0.ctl_op), int'(CTL_CB_OP));
    chk("CB11_cb_mode", int'(bus0.cb_mode), 1);
    chk("CB11_src",     int'(bus0.src_r8), 1);
    chk("CB11_dst",     int'(bus0.dst_r8), 1);
    chk("CB11_count",   int'(bus0.instr_count), cnt_exp(3));

    do_fetch(8'hD3);
    chk("D3_locked",    int'(bus0.locked), 1);
    chk("D3_ctl_op",    int'(bus0.ctl_op), int'(CTL_LOCK));
    chk("D3_opcode",    int'(bus0.opcode), 8'hD3);
    chk("D3_nolock_op", int'(bus1.ctl_op), int'(CTL_NOP));
    chk("D3_nolock_lk", int'(bus1.locked), 0);
    do_fetch(8'h00);
    chk("lock_ir_frozen", int'(bus0.opcode), 8'hD3);
    chk("lock_count",     int'(bus0.instr_count), cnt_exp(4));
    chk("nolock_ir",      int'(bus1.opcode), 8'h00);

    pulse_reset();
    chk("unlock_locked", int'(bus0.locked), 0);
    chk("unlock_opcode", int'(bus0.opcode), 8'h00);
    chk("unlock_ctl_op", int'(bus0.ctl_op), int'(CTL_NOP));

    // Async reset while a CB prefix is pending, checked well before the next clock edge.
    do_fetch(8'hCB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cb_mode", int'(bus0.cb_mode), 0);
    chk("arst_opcode",  int'(bus0.opcode), 8'h00);
    chk("arst_ctl_op",  int'(bus0.ctl_op), int'(CTL_NOP));
    chk("arst_count",   int'(bus0.instr_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_fetch(8'h11);
    chk("arst_main_op", int'(bus0.ctl_op), int'(CTL_UNIMPL));
    chk("arst_main_cb", int'(bus0.cb_mode), 0);

    pulse_reset();
    fetch = 1'b1;
    rdata = 8'h00;
    repeat (17) @(posedge clk);
    #1;
    fetch = 1'b0;
    chk("wrap_count", int'(bus0.instr_count), cnt_exp(17));

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom % 48) != 0;
      fetch = $urandom % 2;
      case ($urandom % 8)
        0:       rdata = 8'hCB;
        1:       rdata = 8'h40 + 8'($urandom % 64);
        2:       rdata = 8'(($urandom % 8) * 8 + 6);
        default: rdata = 8'($urandom);
      endcase
    end
    rst_n = 1'b1;
    fetch = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_cmp = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
